// File: rtl/seg7_hex_writer.sv
// Avalon-MM master: latches a packed hex value and writes one 7-segment pattern per digit.
// Latency: writes on cycles 1..SEG7_NUM after start, done on SEG7_NUM+1; +1 cycle per waitrequest cycle.
// Backpressure: address/data held while m_waitrequest is high; start ignored while busy.
module seg7_hex_writer #(
    parameter int SEG7_NUM            = 8,
    parameter int ADDR_WIDTH          = 3,
    parameter int BLANK_LEADING_ZEROS = 0
) (
    input  logic                    s_clk,
    input  logic                    s_reset,
    input  logic [SEG7_NUM*4-1:0]   value_in,
    input  logic [SEG7_NUM-1:0]     dp_in,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   m_address,
    output logic                    m_write,
    output logic [7:0]              m_writedata,
    input  logic                    m_waitrequest
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]   w_idx_nxt;
    logic [SEG7_NUM*4-1:0]   r_value;
    logic [SEG7_NUM*4-1:0]   w_value_nxt;
    logic [SEG7_NUM-1:0]     r_dp;
    logic [SEG7_NUM-1:0]     w_dp_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_last;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [SEG7_NUM-1:0]     w_blank_vec;
    logic                    w_zero_run;

    function automatic logic [6:0] f_hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Digit i is blank when it and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        w_blank_vec = '0;
        w_zero_run  = 1'b1;
        for (int i = SEG7_NUM - 1; i > 0; i--) begin
            w_zero_run     = w_zero_run && (r_value[i*4 +: 4] == 4'h0);
            w_blank_vec[i] = w_zero_run;
        end
    end

    assign w_nib   = 4'(r_value >> {r_idx, 2'b00});
    assign w_blank = (BLANK_LEADING_ZEROS != 0) && w_blank_vec[r_idx];
    assign w_last  = (r_idx == ADDR_WIDTH'(SEG7_NUM - 1));

    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_value <= '0;
            r_dp    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_value <= w_value_nxt;
            r_dp    <= w_dp_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_value_nxt = r_value;
        w_dp_nxt    = r_dp;
        w_done_nxt  = 1'b0;
        busy        = 1'b0;
        m_write     = 1'b0;
        m_address   = '0;
        m_writedata = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_WRITE;
                    w_idx_nxt   = '0;
                    w_value_nxt = value_in;
                    w_dp_nxt    = dp_in;
                end
            end
            ST_WRITE: begin
                busy        = 1'b1;
                m_write     = 1'b1;
                m_address   = r_idx;
                m_writedata = {r_dp[r_idx], (w_blank ? 7'h00 : f_hex2seg(w_nib))};
                if (!m_waitrequest) begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign done = r_done;

endmodule

// File: tb/tb_seg7_hex_writer.sv
// Directed bench for seg7_hex_writer: one instance without and one with leading-zero blanking.
module tb_seg7_hex_writer;

    logic        clk = 1'b0;
    logic        s_reset;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        start;
    logic        waitreq;

    logic       busy0, done0, m_write0, busy1, done1, m_write1;
    logic [2:0] m_address0, m_address1;
    logic [7:0] m_writedata0, m_writedata1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seg7_hex_writer #(.SEG7_NUM(8), .ADDR_WIDTH(3), .BLANK_LEADING_ZEROS(0)) u_dut0 (
        .s_clk(clk), .s_reset(s_reset), .value_in(value_in), .dp_in(dp_in), .start(start),
        .busy(busy0), .done(done0), .m_address(m_address0), .m_write(m_write0),
        .m_writedata(m_writedata0), .m_waitrequest(waitreq)
    );

    seg7_hex_writer #(.SEG7_NUM(8), .ADDR_WIDTH(3), .BLANK_LEADING_ZEROS(1)) u_dut1 (
        .s_clk(clk), .s_reset(s_reset), .value_in(value_in), .dp_in(dp_in), .start(start),
        .busy(busy1), .done(done1), .m_address(m_address1), .m_write(m_write1),
        .m_writedata(m_writedata1), .m_waitrequest(waitreq)
    );

    typedef struct {
        logic [31:0] value;
        logic [7:0]  dp;
        bit          blank;
        int          wait_addr;
        int          wait_n;
        int          done_cyc;
        logic [63:0] exp;        // {digit7 .. digit0}
        bit          restart;
        bit          chain;
        logic [31:0] chain_value;
        logic [7:0]  chain_dp;
        bit          no_start;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] value, input logic [7:0] dp, input bit blank,
                                input int wait_addr, input int wait_n, input int done_cyc,
                                input logic [63:0] exp);
        vec_t v;
        v.value = value; v.dp = dp; v.blank = blank;
        v.wait_addr = wait_addr; v.wait_n = wait_n; v.done_cyc = done_cyc; v.exp = exp;
        v.restart = 1'b0; v.chain = 1'b0; v.chain_value = '0; v.chain_dp = '0; v.no_start = 1'b0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   got;
        int   wcnt;
        bit   seen;
        logic wr, dn, bz;
        logic [2:0] a;
        logic [7:0] d;
        if (!v.no_start) begin
            @(negedge clk);
            value_in = v.value;
            dp_in    = v.dp;
            start    = 1'b1;
            waitreq  = 1'b0;
        end
        got  = 0;
        wcnt = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (v.restart && c == 4) begin
                start    = 1'b1;
                value_in = 32'hFEDC_BA98;
                dp_in    = 8'hFF;
            end
            wr = v.blank ? m_write1 : m_write0;
            dn = v.blank ? done1 : done0;
            bz = v.blank ? busy1 : busy0;
            a  = v.blank ? m_address1 : m_address0;
            d  = v.blank ? m_writedata1 : m_writedata0;
            if (dn) begin
                seen    = 1'b1;
                waitreq = 1'b0;
                check("done_cycle", c, v.done_cyc);
                check("writes_before_done", got, 8);
                check("busy_in_done_cycle", int'(bz), 0);
                check("m_write_in_done_cycle", int'(wr), 0);
                if (v.chain) begin
                    start    = 1'b1;
                    value_in = v.chain_value;
                    dp_in    = v.chain_dp;
                end
            end else if (got >= 8) begin
                check("extra_write_after_last", int'(wr), 0);
                waitreq = 1'b0;
            end else begin
                check("busy", int'(bz), 1);
                check("m_write", int'(wr), 1);
                check("m_address", int'(a), got);
                check("m_writedata", int'(d), int'(v.exp[got*8 +: 8]));
                if (int'(a) == v.wait_addr && wcnt < v.wait_n) begin
                    waitreq = 1'b1;
                    wcnt++;
                end else begin
                    waitreq = 1'b0;
                    got++;
                end
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        if (!v.chain) begin
            @(negedge clk);
            check("done_single_pulse", int'(v.blank ? done1 : done0), 0);
            check("busy_after_done", int'(v.blank ? busy1 : busy0), 0);
        end
    endtask

    initial begin
        int n_done;
        s_reset  = 1'b1;
        value_in = '0;
        dp_in    = '0;
        start    = 1'b0;
        waitreq  = 1'b0;

        vecs[0] = mk(32'h0123_4567, 8'h00, 1'b0, -1, 0, 9,  64'h3F06_5B4F_666D_7D07);
        vecs[1] = mk(32'h89AB_CDEF, 8'h81, 1'b0,  2, 3, 12, 64'hFF6F_777C_395E_79F1);
        vecs[2] = mk(32'h0000_00A0, 8'h00, 1'b1, -1, 0, 9,  64'h0000_0000_0000_773F);
        vecs[3] = mk(32'h0000_0000, 8'h00, 1'b1, -1, 0, 9,  64'h0000_0000_0000_003F);
        vecs[4] = mk(32'h0010_0200, 8'h00, 1'b1, -1, 0, 9,  64'h0000_063F_3F5B_3F3F);
        vecs[5] = mk(32'h0000_0005, 8'h04, 1'b1, -1, 0, 9,  64'h0000_0000_0080_006D);
        vecs[6] = mk(32'h0123_4567, 8'h00, 1'b0, -1, 0, 9,  64'h3F06_5B4F_666D_7D07);
        vecs[6].restart = 1'b1;
        vecs[7] = mk(32'h0123_4567, 8'h00, 1'b0, -1, 0, 9,  64'h3F06_5B4F_666D_7D07);
        vecs[7].chain = 1'b1;
        vecs[7].chain_value = 32'h0000_000F;
        vecs[7].chain_dp = 8'h02;
        vecs[8] = mk(32'h0000_000F, 8'h02, 1'b0, -1, 0, 9,  64'h3F3F_3F3F_3F3F_BF71);
        vecs[8].no_start = 1'b1;
        vecs[9] = mk(32'h0123_4567, 8'h00, 1'b0,  7, 2, 11, 64'h3F06_5B4F_666D_7D07);

        repeat (3) @(negedge clk);
        s_reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        check("rst_m_write", int'(m_write0), 0);
        check("rst_m_address", int'(m_address0), 0);
        check("rst_m_writedata", int'(m_writedata0), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset on cycle 5 of an update: write drops next cycle, no done afterwards.
        @(negedge clk);
        value_in = 32'h0123_4567;
        dp_in    = 8'h00;
        start    = 1'b1;
        waitreq  = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_reset_m_write", int'(m_write0), 1);
        check("pre_reset_m_address", int'(m_address0), 4);
        s_reset = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
        check("post_reset_m_write", int'(m_write0), 0);
        check("post_reset_busy", int'(busy0), 0);
        check("post_reset_done", int'(done0), 0);
        n_done = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done0 || m_write0) n_done++;
        end
        check("no_activity_after_reset", n_done, 0);

        run_vec(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_hex_writer.md
Name: seg7_hex_writer

Overview:
Avalon-MM master that drives the 7-segment register-file slave. It converts a packed hexadecimal value into per-digit segment patterns and issues one 8-bit write per digit. This lets hardware, rather than the Nios software, refresh the display. It sits between a value source (counter, measurement block) and the 7-segment slave's s1 port.

Parameters:
SEG7_NUM, 8, number of digits written per update
ADDR_WIDTH, 3, master address width; log2(SEG7_NUM)
BLANK_LEADING_ZEROS, 0, 1 means leading zero digits (except digit 0) are written as blank

Ports:
s_clk  in  1  clock
s_reset  in  1  reset; synchronous, active-high
value_in  in  SEG7_NUM*4  packed hex digits; nibble i (bits 4i+3:4i) goes to digit i
dp_in  in  SEG7_NUM  decimal point per digit; bit i drives digit i bit 7
start  in  1  one-cycle request to begin an update; ignored unless idle
busy  out  1  high while an update is in progress
done  out  1  one-cycle pulse after the last write is accepted
m_address  out  ADDR_WIDTH  digit index of the current write
m_write  out  1  write request
m_writedata  out  8  segment pattern, bit0=seg a .. bit6=seg g, bit7=dp; 1 means on
m_waitrequest  in  1  slave stall

Behaviour:
- Clocking and reset: one clock, s_clk. Reset is synchronous and active-high on s_reset.
- Reset values: busy=0, done=0, m_write=0, m_address=0, m_writedata=0x00, FSM in IDLE, digit index 0.
- FSM states: IDLE, WRITE.
- IDLE:
  - start=1 latches value_in and dp_in into internal registers, clears the index to 0, and moves to WRITE.
  - busy rises on the next cycle.
- WRITE:
  - m_write=1, m_address=index, m_writedata=pattern(index).
  - Address and data are held stable while m_waitrequest=1.
  - A write is accepted when m_write=1 and m_waitrequest=0.
  - On acceptance with index < SEG7_NUM-1: index increments, and the next write is presented on the following cycle with no idle gap.
  - On acceptance with index = SEG7_NUM-1: go to IDLE, deassert m_write and busy, and pulse done=1 for exactly one cycle.
- Pattern encoding: low 7 bits come from the nibble map:
  - 0-7: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07
  - 8-F: 0x7F, 0x6F, 0x77, 0x7C, 0x39, 0x5E, 0x79, 0x71
  - Bit 7 = latched dp bit for that digit.
- Blanking (BLANK_LEADING_ZEROS=1):
  - Digit i>0 is blank when latched nibbles i..SEG7_NUM-1 are all zero.
  - A blank digit writes low 7 bits = 0; its dp bit still applies.
  - Digit 0 is never blanked.
- Latency with m_waitrequest=0:
  - start seen at cycle 0.
  - Writes presented on cycles 1..SEG7_NUM.
  - done on cycle SEG7_NUM+1.
  - Each waitrequest cycle adds one cycle.
- start while busy: ignored; the latched value is unchanged.
- start during the done cycle: accepted, since the FSM is already IDLE.
- value_in and dp_in changing mid-update have no effect.
- Reset mid-update:
  - Aborts immediately; no done pulse.
  - m_write drops in the same clock edge; the partially written display is left as is.
- Polarity: no low-active inversion here; the slave applies panel polarity.

Test Plan:
- value_in=0x01234567, dp_in=0x00, waitrequest=0, start at cycle 0 -> writes (addr,data):
  - (0,0x07) (1,0x7D) (2,0x6D) (3,0x66) (4,0x4F) (5,0x5B) (6,0x06) (7,0x3F) on cycles 1-8.
  - done=1 on cycle 9 only; busy high on cycles 1-8.
- value_in=0x89ABCDEF, dp_in=0x81, waitrequest held high 3 cycles on the addr 2 write -> addr/data stay (2,0x5E) for 4 cycles, then continue.
  - Full sequence: 0xF1 0x79 0x5E 0x39 0x7C 0x77 0x6F 0xFF.
  - done on cycle 12.
- BLANK_LEADING_ZEROS=1:
  - value_in=0x000000A0 -> (0,0x3F) (1,0x77), addr 2-7 data 0x00.
  - value_in=0 -> addr 0 data 0x3F, addr 1-7 data 0x00.
- start pulsed again on cycle 4 with a different value_in -> ignored; sequence identical to the first test, single done.
- s_reset asserted on cycle 5 of an update -> next cycle m_write=0, busy=0, no done.
  - A following start restarts at addr 0.
- start asserted in the done cycle -> new update begins; the first write appears on the next cycle.
